// File: rtl/multimode_game_engine.sv
// multimode_game_engine: step counter with win/lose hit counting and an
// IDLE/PLAY/OVER game state machine. Game-over is sticky until acknowledged.
module multimode_game_engine #(
   parameter int WIDTH   = 4,
   parameter int STEP    = 2,
   parameter int HIT_MAX = 15,
   parameter int CW      = $clog2(HIT_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic [WIDTH-1:0] initial_val,
   input  logic [1:0]       control,
   input  logic             en,
   input  logic             ack,
   output logic [WIDTH-1:0] count,
   output logic             winner,
   output logic             loser,
   output logic [CW-1:0]    win_cnt,
   output logic [CW-1:0]    lose_cnt,
   output logic             gameover,
   output logic [1:0]       who
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [CW-1:0]    HIT_LIM  = CW'(HIT_MAX);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             winner_q, winner_d;
   logic             loser_q, loser_d;
   logic [CW-1:0]    win_cnt_q, win_cnt_d;
   logic [CW-1:0]    lose_cnt_q, lose_cnt_d;
   logic             gameover_q, gameover_d;
   logic [1:0]       who_q, who_d;

   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] next_count;
   logic [CW-1:0]    win_inc;
   logic [CW-1:0]    lose_inc;

   // Next-state and next-output logic for the game FSM.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      winner_d   = 1'b0;
      loser_d    = 1'b0;
      win_cnt_d  = win_cnt_q;
      lose_cnt_d = lose_cnt_q;
      gameover_d = gameover_q;
      who_d      = who_q;

      // control[0] selects the large step, control[1] selects decrement;
      // arithmetic wraps naturally at WIDTH bits.
      step_val   = control[0] ? STEP_W : ONE_W;
      next_count = control[1] ? (count_q - step_val) : (count_q + step_val);
      win_inc    = win_cnt_q + CNT_ONE;
      lose_inc   = lose_cnt_q + CNT_ONE;

      case (state_q)
         S_IDLE: begin
            if (init) begin
               count_d    = initial_val;
               win_cnt_d  = '0;
               lose_cnt_d = '0;
               state_d    = S_PLAY;
            end
         end

         S_PLAY: begin
            if (init) begin
               // A load never counts as a hit, even when it lands on 0 or all-ones.
               count_d    = initial_val;
               win_cnt_d  = '0;
               lose_cnt_d = '0;
            end else if (en) begin
               count_d = next_count;
               if (next_count == '0) begin
                  loser_d    = 1'b1;
                  lose_cnt_d = lose_inc;
                  if (lose_inc == HIT_LIM) begin
                     state_d    = S_OVER;
                     gameover_d = 1'b1;
                     who_d      = 2'd1;
                  end
               end else if (next_count == ALL_ONES) begin
                  winner_d  = 1'b1;
                  win_cnt_d = win_inc;
                  if (win_inc == HIT_LIM) begin
                     state_d    = S_OVER;
                     gameover_d = 1'b1;
                     who_d      = 2'd2;
                  end
               end
            end
         end

         S_OVER: begin
            // ack clears the game; init arriving alongside it is dropped.
            if (ack) begin
               state_d    = S_IDLE;
               count_d    = '0;
               win_cnt_d  = '0;
               lose_cnt_d = '0;
               gameover_d = 1'b0;
               who_d      = 2'd0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         winner_q   <= 1'b0;
         loser_q    <= 1'b0;
         win_cnt_q  <= '0;
         lose_cnt_q <= '0;
         gameover_q <= 1'b0;
         who_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         winner_q   <= winner_d;
         loser_q    <= loser_d;
         win_cnt_q  <= win_cnt_d;
         lose_cnt_q <= lose_cnt_d;
         gameover_q <= gameover_d;
         who_q      <= who_d;
      end
   end

   assign count    = count_q;
   assign winner   = winner_q;
   assign loser    = loser_q;
   assign win_cnt  = win_cnt_q;
   assign lose_cnt = lose_cnt_q;
   assign gameover = gameover_q;
   assign who      = who_q;

endmodule

// File: doc/multimode_game_engine.md
# multimode_game_engine

Parametrised successor to the fixed 4-bit multimode counter game. It folds the step counter, the win/lose hit counters and the winner decision into one block with an explicit IDLE/PLAY/OVER state machine. Counter width, the large step size and the hit threshold are configurable. It adds a count enable, a sticky game-over held until acknowledged, and visible hit counts. It sits under the game top level, which drives the player controls and reads `gameover`/`who`.

## Interface
- `WIDTH`, 4, main counter width in bits; must be ≥ 2.
- `STEP`, 2, large step magnitude; must satisfy 1 ≤ STEP < 2^WIDTH.
- `HIT_MAX`, 15, number of winner (or loser) hits that ends a game; must be ≥ 1.
- `CW`, $clog2(HIT_MAX+1), hit counter width (derived; do not override).
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `init`  in  1  load strobe: count ← `initial_val`.
- `initial_val`  in  WIDTH  load value.
- `control`  in  2  step mode: 0 = +1, 1 = +STEP, 2 = −1, 3 = −STEP.
- `en`  in  1  count enable; one step per enabled cycle.
- `ack`  in  1  acknowledges game-over and returns the block to IDLE.
- `count`  out  WIDTH  current counter value.
- `winner`  out  1  one-cycle pulse: count just became all-ones.
- `loser`  out  1  one-cycle pulse: count just became zero.
- `win_cnt`  out  CW  winner hits in the current game.
- `lose_cnt`  out  CW  loser hits in the current game.
- `gameover`  out  1  high while in OVER.
- `who`  out  2  0 = none, 1 = loser side won, 2 = winner side won; 3 is never driven.

## Operation
- All outputs are registered. Reset value of every output is 0, and reset places the FSM in IDLE.
- `rst` has priority over every other input in every state.

IDLE
- `init` loads count ← `initial_val` and moves to PLAY.
- All other inputs are ignored; count holds.

PLAY, in priority order:
- `init`: count ← `initial_val`, win_cnt ← 0, lose_cnt ← 0. No hit is generated.
- `en`: next = count ± step, computed modulo 2^WIDTH (wrap, no saturation).
  - next == 0: `loser` = 1 and lose_cnt increments.
  - next == 2^WIDTH−1: `winner` = 1 and win_cnt increments.
  - Both conditions cannot occur together because WIDTH ≥ 2.
- Neither `init` nor `en`: count holds and the pulses are 0.
- When win_cnt reaches HIT_MAX on an increment: go to OVER with `who` = 2. When lose_cnt reaches HIT_MAX: go to OVER with `who` = 1.
- A load is never a hit. Loading 0 or all-ones produces no pulse and no count change.

OVER
- `gameover` = 1; `who`, count, win_cnt and lose_cnt all hold.
- `en`, `control` and `init` are ignored.
- `ack` moves to IDLE and clears count, win_cnt, lose_cnt, `who` and `gameover`. If `init` and `ack` are high together, `ack` wins and `init` is dropped.

## Timing
- Latency is 1 cycle from sampled `en` to the updated count. `winner`/`loser` and the hit counter increment appear on that same edge.
- `winner`/`loser` stay high exactly one cycle per hit. Consecutive enabled cycles can produce back-to-back pulses.
- The edge that raises the final hit count to HIT_MAX also raises `gameover`, sets `who`, and shows that final pulse. The next cycle is in OVER with the pulses at 0.
- `init` takes effect on the next edge.
- `ack` in OVER clears state on the next edge. The earliest new `init` is accepted on the cycle after that edge, from IDLE.
- `rst` asserted mid-game: all outputs read 0 one edge later, and any hit in progress is discarded.
- `control` is sampled only when `en` = 1.

## Test plan
All scenarios use WIDTH = 4, STEP = 2, HIT_MAX = 3.
- Reset/idle: pulse `rst`, then drive `en` = 1 for 5 cycles without `init` → count = 0, `loser` = 0, every output = 0.
- Load and win hit: `init` with `initial_val` = 14, then `en` = 1, `control` = 0 → count = 15, `winner` = 1 for one cycle, win_cnt = 1.
- Load is not a hit: `init` with `initial_val` = 0 → count = 0, `loser` = 0, lose_cnt = 0.
- Wrap both ways: from count = 15, `control` = 0 → count = 0 with `loser`. From count = 1, `control` = 3 → count = 15 with `winner`.
- Game end: produce 3 loser hits → on the 3rd hit's edge `gameover` = 1 and `who` = 1. Then `en` for 4 cycles → count holds. Then `ack` together with `init` → next cycle all outputs = 0 and the FSM is in IDLE (`init` ignored).
- Mid-game reload and reset:
  - With win_cnt = 2, `init` with `initial_val` = 5 → win_cnt = 0, count = 5.
  - Then 2 winner hits → no gameover.
  - Then `rst` → all outputs = 0.
